// File: rtl/led_ctrl_fsm_if.sv
// Datapath-facing bundle of the LED cube controller: strobes, levels and the
// captured switch word going out, countdown/recolour flags coming back.
interface led_ctrl_fsm_if;
   logic [8:0] data;
   logic       load;
   logic       off;
   logic       cda;
   logic       pos;
   logic       cho_c;
   logic       ans;
   logic       pause;
   logic       cda_done;
   logic       rcm;

   modport master (
      output data, load, off, cda, pos, cho_c, ans, pause,
      input  cda_done, rcm
   );

   modport slave (
      input  data, load, off, cda, pos, cho_c, ans, pause,
      output cda_done, rcm
   );
endinterface

// File: rtl/led_ctrl_fsm.sv
// LED cube control stage: key conditioning (sync, debounce, edge detect) and
// the user-flow sequencer driving the cube datapath.
//
// state      | meaning
// S_OFF      | cube blank, waiting for go
// S_CDA      | countdown animation running until cda_done
// S_POS_WAIT | waiting for go to capture position switches
// S_POS      | one-cycle position load strobe
// S_COL_WAIT | waiting for go to capture colour switches
// S_COL      | one-cycle colour load strobe
// S_RCM_CHK  | single-cycle look at the datapath recolour flag
// S_ANIM     | animation running, pause toggles allowed
module led_ctrl_fsm #(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int CNT_W           = 20
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             go_key,
   input  logic             pause_key,
   input  logic             clear_key,
   input  logic [8:0]       sw,
   led_ctrl_fsm_if.master   dp
);

   localparam logic [CNT_W-1:0] DB_TC = CNT_W'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [2:0] {
      S_OFF      = 3'd0,
      S_CDA      = 3'd1,
      S_POS_WAIT = 3'd2,
      S_POS      = 3'd3,
      S_COL_WAIT = 3'd4,
      S_COL      = 3'd5,
      S_RCM_CHK  = 3'd6,
      S_ANIM     = 3'd7
   } state_t;

   state_t           state, state_nxt;
   logic [2:0]       key_raw, key_s1, key_s2, key_stable, key_stable_d, key_press;
   logic [CNT_W-1:0] db_cnt [3];
   logic             go_press, pause_press, clear_press;
   logic [8:0]       data_q;
   logic             pause_q;
   logic             load_o, off_o, cda_o, pos_o, cho_c_o, ans_o;

   assign key_raw = {clear_key, pause_key, go_key};

   // Counter runs only while the synchronized sample disagrees with the
   // accepted level; any sample matching the accepted level restarts it.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         key_s1       <= '0;
         key_s2       <= '0;
         key_stable   <= '0;
         key_stable_d <= '0;
         for (int i = 0; i < 3; i++) db_cnt[i] <= '0;
      end else begin
         key_s1       <= key_raw;
         key_s2       <= key_s1;
         key_stable_d <= key_stable;
         for (int i = 0; i < 3; i++) begin
            if (key_s2[i] == key_stable[i]) begin
               db_cnt[i] <= '0;
            end else if (db_cnt[i] == DB_TC) begin
               key_stable[i] <= key_s2[i];
               db_cnt[i]     <= '0;
            end else begin
               db_cnt[i] <= db_cnt[i] + CNT_W'(1);
            end
         end
      end
   end

   assign key_press   = key_stable & ~key_stable_d;
   assign go_press    = key_press[0];
   assign pause_press = key_press[1];
   assign clear_press = key_press[2];

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) state <= S_OFF;
      else         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (clear_press && state != S_OFF) begin
         state_nxt = S_OFF;
      end else begin
         case (state)
            S_OFF:      if (go_press) state_nxt = S_CDA;
            S_CDA:      if (dp.cda_done) state_nxt = S_POS_WAIT;
            S_POS_WAIT: if (go_press) state_nxt = S_POS;
            S_POS:      state_nxt = S_COL_WAIT;
            S_COL_WAIT: if (go_press) state_nxt = S_COL;
            S_COL:      state_nxt = S_RCM_CHK;
            S_RCM_CHK:  state_nxt = dp.rcm ? S_POS_WAIT : S_ANIM;
            S_ANIM:     if (go_press) state_nxt = S_POS_WAIT;
            default:    state_nxt = S_OFF;
         endcase
      end
   end

   always_comb begin
      load_o  = 1'b0;
      off_o   = 1'b0;
      cda_o   = 1'b0;
      pos_o   = 1'b0;
      cho_c_o = 1'b0;
      ans_o   = 1'b0;
      case (state)
         S_OFF:  off_o = 1'b1;
         S_CDA:  cda_o = 1'b1;
         S_POS:  begin pos_o = 1'b1;   load_o = 1'b1; end
         S_COL:  begin cho_c_o = 1'b1; load_o = 1'b1; end
         S_ANIM: ans_o = 1'b1;
         default: ;
      endcase
   end

   // Capture only on transitions that actually leave the wait states, so a
   // simultaneous clear leaves the word untouched.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         data_q <= '0;
      end else if (state == S_POS_WAIT && state_nxt == S_POS) begin
         data_q <= sw;
      end else if (state == S_COL_WAIT && state_nxt == S_COL) begin
         data_q <= {6'b0, sw[2:0]};
      end
   end

   // Leaving S_ANIM for any reason clears pause, which also lets go beat pause.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         pause_q <= 1'b0;
      end else if (state_nxt != S_ANIM) begin
         pause_q <= 1'b0;
      end else if (state == S_ANIM && pause_press) begin
         pause_q <= ~pause_q;
      end
   end

   assign dp.data  = data_q;
   assign dp.load  = load_o;
   assign dp.off   = off_o;
   assign dp.cda   = cda_o;
   assign dp.pos   = pos_o;
   assign dp.cho_c = cho_c_o;
   assign dp.ans   = ans_o;
   assign dp.pause = pause_q;

endmodule
